ysyx_23060124_ifu: RTL and testbench
====================================

Name: ysyx_23060124_ifu

Overview:
Instruction fetch unit and the producer end of the instruction word consumed by the decode stage.
- Holds the PC and issues one word request at a time to instruction memory over a req/gnt + rvalid interface.
- Presents each fetched word with its PC to decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute and squashes wrong-path fetches.

Parameters:
ISA_WIDTH, 32, instruction word width
ADDR_W, 32, PC / fetch address width
RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_redirect  input  1  execute stage: taken branch/jal/jalr this cycle
i_redirect_pc  input  ADDR_W  redirect target
o_imem_req  output  1  fetch request valid
o_imem_addr  output  ADDR_W  fetch address
i_imem_gnt  input  1  memory accepts request this cycle
i_imem_rvalid  input  1  response data valid (single cycle)
i_imem_rdata  input  ISA_WIDTH  fetched word
o_ins_valid  output  1  instruction available to decode
o_ins  output  ISA_WIDTH  instruction word
o_pc  output  ADDR_W  PC of o_ins
i_ins_ready  input  1  decode accepts instruction

Behaviour:
- Reset (i_rst_n=0 at edge): state=S_IDLE, pc=RESET_PC, drop=0, o_ins_valid=0, o_ins=0, o_pc=RESET_PC. o_imem_req=0, o_imem_addr=pc.
- States:
  - S_IDLE: unconditionally to S_REQ next cycle.
  - S_REQ: o_imem_req=1, o_imem_addr=pc. On gnt, go to S_WAIT. Address is held stable while req && !gnt, except on redirect.
  - S_WAIT: on rvalid with drop=0, latch rdata into o_ins and pc into o_pc, set o_ins_valid, go to S_HOLD. On rvalid with drop=1, discard the word, clear drop, go to S_REQ.
  - S_HOLD: o_ins/o_pc/o_ins_valid stable until fire = o_ins_valid & i_ins_ready & !i_redirect. On fire: o_ins_valid=0, pc=pc+4, go to S_REQ.
- i_imem_rvalid is ignored outside S_WAIT.
- Latency: gnt at cycle N, rvalid at cycle M>N, o_ins_valid high from M+1. With zero-wait memory, peak rate is one instruction per 3 cycles.
- Redirect has priority over every other event. Target is pc_new = {i_redirect_pc[ADDR_W-1:2],2'b00}; low bits are forced to 0. pc updates to pc_new at the edge. The response per state:
  - S_IDLE: pc=pc_new, go to S_REQ.
  - S_REQ without gnt: stay; next cycle addr=pc_new. This is the only permitted address change while req is pending.
  - S_REQ with gnt same cycle: the old-address fetch is in flight. Go to S_WAIT with drop=1.
  - S_WAIT without rvalid: drop=1, stay.
  - S_WAIT with rvalid: discard the word, go to S_REQ.
  - S_HOLD: o_ins_valid=0 next cycle even if i_ins_ready=1; the held word is not transferred. Go to S_REQ.
- Valid/ready rules:
  - o_ins_valid never deasserts without fire, except on redirect.
  - o_ins_valid does not depend combinationally on i_ins_ready.
- PC arithmetic is modulo 2^ADDR_W: pc=32'hFFFF_FFFC plus 4 gives 32'h0.
- Reset mid-operation returns to the reset state immediately. Instruction memory shares i_rst_n, so no stale response follows reset.

Test Plan:
- Reset, then zero-wait memory returning 32'h00000413 @8000_0000 and 32'h00100073 @8000_0004, i_ins_ready=1:
  - o_imem_addr sequence is 8000_0000, 8000_0004.
  - o_ins_valid high one cycle after each rvalid, with matching o_pc/o_ins.
- Backpressure: i_ins_ready=0 for 5 cycles while valid, then 1:
  - o_ins/o_pc stable throughout.
  - No new o_imem_req until the cycle after fire.
- Redirect to 8000_0100 in the same cycle as gnt for 8000_0008:
  - Response for 8000_0008 is discarded; o_ins_valid stays 0.
  - Next request addr is 8000_0100.
- Redirect to 8000_0203 while in S_HOLD with i_ins_ready=1:
  - No transfer occurs; o_ins_valid=0 next cycle.
  - Next request addr is 8000_0200.
- PC wrap: RESET_PC=32'hFFFF_FFFC, fetch and accept one word:
  - Next o_imem_addr is 32'h0000_0000.
- Reset asserted in S_WAIT:
  - Next edge: o_ins_valid=0, o_imem_req=0, o_pc=RESET_PC.
  - Request to RESET_PC issued 2 cycles after reset release.

Source files
------------

// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: owns the PC and fetches one word at a time from instruction memory.
// It hands each fetched word and its PC to decode, and squashes wrong-path fetches on redirect.
module ysyx_23060124_ifu #(
    parameter int unsigned        ISA_WIDTH = 32,
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(32'h8000_0000)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_redirect,
    input  logic [ADDR_W-1:0]    i_redirect_pc,
    output logic                 o_imem_req,
    output logic [ADDR_W-1:0]    o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [ISA_WIDTH-1:0] i_imem_rdata,
    output logic                 o_ins_valid,
    output logic [ISA_WIDTH-1:0] o_ins,
    output logic [ADDR_W-1:0]    o_pc,
    input  logic                 i_ins_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic                   drop_q, drop_d;
    logic                   ins_valid_q, ins_valid_d;
    logic [ISA_WIDTH-1:0]   ins_q, ins_d;
    logic [ADDR_W-1:0]      ins_pc_q, ins_pc_d;

    logic [ADDR_W-1:0]      pc_new;
    logic                   fire;

    assign pc_new = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    // A redirect cancels the handshake, so the held word is never transferred that cycle.
    assign fire   = ins_valid_q & i_ins_ready & ~i_redirect;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        ins_valid_d = ins_valid_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (i_redirect) begin
                    pc_d = pc_new;
                end
            end

            StReq: begin
                if (i_redirect) begin
                    pc_d = pc_new;
                end
                if (i_imem_gnt) begin
                    // Old-address fetch already accepted: mark its response for discard.
                    state_d = StWait;
                    drop_d  = i_redirect;
                end
            end

            StWait: begin
                if (i_redirect) begin
                    pc_d = pc_new;
                    if (i_imem_rvalid) begin
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (i_imem_rvalid) begin
                    if (drop_q) begin
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        state_d     = StHold;
                        ins_valid_d = 1'b1;
                        ins_d       = i_imem_rdata;
                        ins_pc_d    = pc_q;
                    end
                end
            end

            StHold: begin
                if (i_redirect) begin
                    state_d     = StReq;
                    ins_valid_d = 1'b0;
                    pc_d        = pc_new;
                end else if (fire) begin
                    state_d     = StReq;
                    ins_valid_d = 1'b0;
                    pc_d        = pc_q + ADDR_W'(4);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            ins_valid_q <= 1'b0;
            ins_q       <= '0;
            ins_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            ins_valid_q <= ins_valid_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
        end
    end

    assign o_imem_req  = (state_q == StReq);
    assign o_imem_addr = pc_q;
    assign o_ins_valid = ins_valid_q;
    assign o_ins       = ins_q;
    assign o_pc        = ins_pc_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Bench for ysyx_23060124_ifu: directed cycle table, PC wrap on a second instance,
// and a randomized run against a transaction-level fetch model.
module tb_ysyx_23060124_ifu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 8000_0000)
    logic        rst_n = 1'b0, redirect = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
    logic [31:0] redirect_pc = '0, rdata = '0;
    logic        req, valid;
    logic [31:0] addr, ins, pc;

    // Wrap instance (RESET_PC = FFFF_FFFC)
    logic        w_rst_n = 1'b0, w_redirect = 1'b0, w_gnt = 1'b0, w_rvalid = 1'b0, w_ready = 1'b0;
    logic [31:0] w_redirect_pc = '0, w_rdata = '0;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_ins, w_pc;

    ysyx_23060124_ifu dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
        .i_imem_rdata(rdata), .o_ins_valid(valid), .o_ins(ins), .o_pc(pc),
        .i_ins_ready(ready)
    );

    ysyx_23060124_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_redirect(w_redirect), .i_redirect_pc(w_redirect_pc),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(w_gnt), .i_imem_rvalid(w_rvalid),
        .i_imem_rdata(w_rdata), .o_ins_valid(w_valid), .o_ins(w_ins), .o_pc(w_pc),
        .i_ins_ready(w_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_0004) return 32'h0010_0073;
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    typedef struct {
        logic        chk, full;
        logic        rst_n, redir;
        logic [31:0] rpc;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ins, e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic chk, input logic full, input logic r, input logic rd,
                                input logic [31:0] rpc, input logic g, input logic rv,
                                input logic [31:0] rdat, input logic rdy, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep);
        vec_t v;
        v.chk = chk; v.full = full; v.rst_n = r; v.redir = rd; v.rpc = rpc; v.gnt = g;
        v.rvalid = rv; v.rdata = rdat; v.ready = rdy; v.e_req = er; v.e_addr = ea;
        v.e_valid = ev; v.e_ins = ei; v.e_pc = ep;
        vecs.push_back(v);
    endfunction

    // Random-phase model state
    logic [31:0] exp_pc, paddr, held_ins, held_pc;
    logic        pending, hold_prev;
    int          cnt, fires;

    initial begin
        // Each row: outputs expected at the start of the cycle, then inputs driven for its edge.
        add(0,0, 0,0,0,            0,0,0,            0, 0,0,            0,0,0);
        add(1,1, 1,0,0,            0,0,0,            0, 0,32'h8000_0000,0,0,32'h8000_0000);
        add(1,0, 1,0,0,            1,0,0,            1, 1,32'h8000_0000,0,0,0);
        add(1,0, 1,0,0,            0,1,32'h0000_0413,1, 0,0,            0,0,0);
        add(1,0, 1,0,0,            0,0,0,            1, 0,0,            1,32'h0000_0413,32'h8000_0000);
        add(1,0, 1,0,0,            1,0,0,            1, 1,32'h8000_0004,0,0,0);
        add(1,0, 1,0,0,            0,1,32'h0010_0073,1, 0,0,            0,0,0);
        for (int k = 0; k < 5; k++)
            add(1,0, 1,0,0,        0,0,0,            0, 0,0,            1,32'h0010_0073,32'h8000_0004);
        add(1,0, 1,0,0,            0,0,0,            1, 0,0,            1,32'h0010_0073,32'h8000_0004);
        add(1,0, 1,1,32'h8000_0100,1,0,0,            1, 1,32'h8000_0008,0,0,0);
        add(1,0, 1,0,0,            0,1,32'hDEAD_BEEF,1, 0,0,            0,0,0);
        add(1,0, 1,0,0,            1,0,0,            1, 1,32'h8000_0100,0,0,0);
        add(1,0, 1,0,0,            0,1,32'h1111_1111,1, 0,0,            0,0,0);
        add(1,0, 1,1,32'h8000_0203,0,0,0,            1, 0,0,            1,32'h1111_1111,32'h8000_0100);
        add(1,0, 1,0,0,            1,0,0,            1, 1,32'h8000_0200,0,0,0);
        add(1,0, 0,0,0,            0,0,0,            0, 0,0,            0,0,0);
        add(1,1, 1,0,0,            0,0,0,            0, 0,32'h8000_0000,0,0,32'h8000_0000);
        add(1,0, 1,1,32'h8000_0040,0,0,0,            0, 1,32'h8000_0000,0,0,0);
        add(1,0, 1,0,0,            1,0,0,            0, 1,32'h8000_0040,0,0,0);
        add(1,0, 1,1,32'h8000_0080,0,0,0,            0, 0,0,            0,0,0);
        add(1,0, 1,0,0,            0,1,32'hCAFE_F00D,0, 0,0,            0,0,0);
        add(1,0, 1,0,0,            0,0,0,            0, 1,32'h8000_0080,0,0,0);
        add(1,0, 1,0,0,            0,0,0,            0, 1,32'h8000_0080,0,0,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].chk) begin
                cmp($sformatf("row%0d_req", i), {31'b0, req}, {31'b0, vecs[i].e_req});
                cmp($sformatf("row%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
                if (vecs[i].e_req || vecs[i].full)
                    cmp($sformatf("row%0d_addr", i), addr, vecs[i].e_addr);
                if (vecs[i].e_valid || vecs[i].full) begin
                    cmp($sformatf("row%0d_ins", i), ins, vecs[i].e_ins);
                    cmp($sformatf("row%0d_pc", i), pc, vecs[i].e_pc);
                end
            end
            rst_n = vecs[i].rst_n; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            gnt = vecs[i].gnt; rvalid = vecs[i].rvalid; rdata = vecs[i].rdata;
            ready = vecs[i].ready;
        end

        // PC wrap: fetch and accept one word at FFFF_FFFC
        @(negedge clk); w_rst_n = 1'b0;
        @(negedge clk); cmp("wrap_reset_pc", w_pc, 32'hFFFF_FFFC); w_rst_n = 1'b1;
        @(negedge clk); cmp("wrap_req", {31'b0, w_req}, 32'd1);
        cmp("wrap_addr0", w_addr, 32'hFFFF_FFFC); w_gnt = 1'b1;
        @(negedge clk); w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0000_0013;
        @(negedge clk); w_rvalid = 1'b0;
        cmp("wrap_valid", {31'b0, w_valid}, 32'd1); cmp("wrap_ins", w_ins, 32'h0000_0013);
        w_ready = 1'b1;
        @(negedge clk); w_ready = 1'b0;
        cmp("wrap_req2", {31'b0, w_req}, 32'd1); cmp("wrap_addr1", w_addr, 32'h0000_0000);

        // Randomized run against the fetch-stream model
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_pc = 32'h8000_0000; pending = 1'b0; hold_prev = 1'b0; cnt = 0; fires = 0;
        held_ins = '0; held_pc = '0; paddr = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (hold_prev) begin
                cmp("hold_valid", {31'b0, valid}, 32'd1);
                cmp("hold_ins", ins, held_ins);
                cmp("hold_pc", pc, held_pc);
            end
            gnt = req && ($urandom_range(0, 2) != 0);
            rvalid = 1'b0; rdata = '0;
            if (pending) begin
                if (cnt == 0) begin
                    rvalid = 1'b1; rdata = mem_word(paddr); pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            redirect = ($urandom_range(0, 19) == 0);
            redirect_pc = {16'h8000, 16'($urandom)};
            ready = ($urandom_range(0, 3) != 0);
            if (req && gnt) begin
                cmp("fetch_addr", addr, exp_pc);
                pending = 1'b1; paddr = addr; cnt = $urandom_range(0, 3);
            end
            hold_prev = valid && !ready && !redirect;
            held_ins = ins; held_pc = pc;
            if (valid && ready && !redirect) begin
                cmp("fire_pc", pc, exp_pc);
                cmp("fire_ins", ins, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                fires++;
            end
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
        end
        cmp("progress", {31'b0, fires > 50}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
